// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the mmio_timer peripheral: register offsets, CTRL
// layout, RV32I load/store funct3 encodings and the CTRL write mask helper.
package mmio_timer_pkg;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_COUNT   = 5'h04;
  localparam logic [4:0] OFF_COMPARE = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_DUTY    = 5'h10;

  localparam int unsigned CTRL_ENABLE       = 0;
  localparam int unsigned CTRL_AUTO_RELOAD  = 1;
  localparam int unsigned CTRL_IRQ_EN       = 2;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic [23:0] prescale;
    logic [4:0]  rsvd;
    logic        irq_en;
    logic        auto_reload;
    logic        enable;
  } ctrl_t;

  // Bits of CTRL that hold state; everything else reads back as zero.
  function automatic logic [31:0] ctrl_mask(input int unsigned prescale_w);
    logic [31:0] m;
    m = '0;
    m[CTRL_ENABLE]      = 1'b1;
    m[CTRL_AUTO_RELOAD] = 1'b1;
    m[CTRL_IRQ_EN]      = 1'b1;
    for (int unsigned i = 0; i < 24; i++) begin
      if (i < prescale_w) m[CTRL_PRESCALE_LSB + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// Byte-lane handling for 32-bit data-memory style responders: store merge
// into an existing word and load extract/extend, both from funct3 + addr[1:0].
module mmio_lane_align
  import mmio_timer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] old_word,
  output logic        store_ok,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [31:0] wdata_pos;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin : store_path
    store_ok    = 1'b1;
    byte_en     = '0;
    wdata_pos   = store_data;
    merged_word = old_word;
    case (funct3)
      SB: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_pos = {4{store_data[7:0]}};
      end
      SH: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_pos = {2{store_data[15:0]}};
      end
      SW:      byte_en  = '1;
      default: store_ok = 1'b0;
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = wdata_pos[8*i +: 8];
    end
  end

  always_comb begin : load_path
    ld_byte = old_word[7:0];
    case (addr_lo)
      2'd0: ld_byte = old_word[7:0];
      2'd1: ld_byte = old_word[15:8];
      2'd2: ld_byte = old_word[23:16];
      2'd3: ld_byte = old_word[31:24];
    endcase
    ld_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    case (funct3)
      LB:      load_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      load_data = {{16{ld_half[15]}}, ld_half};
      LBU:     load_data = {24'h0, ld_byte};
      LHU:     load_data = {16'h0, ld_half};
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare match, level irq and optional
// PWM output (DUTY register at 0x10) enabled by defining MMIO_TIMER_PWM_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  output logic [31:0] dmem_data_out,
  output logic        hit,
  output logic        irq,
  output logic        pwm_out
);
  import mmio_timer_pkg::*;

  ctrl_t                 ctrl_q, ctrl_d;
  logic [31:0]           count_q, count_d, compare_q, compare_d;
  logic                  match_q, match_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d, prescale;
  logic                  sel, wr, tick, match_hit, store_ok, pwm_d;
  logic [2:0]            idx;
  logic [3:0]            byte_en;
  logic [31:0]           rd_word, merged_word, load_data;
`ifdef MMIO_TIMER_PWM_EN
  logic [31:0]           duty_q, duty_d;
`endif

  assign sel       = (dmem_address[31:5] == BASE_ADDR[31:5]);
  assign idx       = dmem_address[4:2];
  assign prescale  = ctrl_q.prescale[PRESCALE_W-1:0];
  assign tick      = ctrl_q.enable && (pcnt_q == prescale);
  assign match_hit = tick && (count_q == compare_q);
  assign wr        = dmem_wren && sel && store_ok;

  always_comb begin : read_mux
    rd_word = '0;
    case ({idx, 2'b00})
      OFF_CTRL:    rd_word = ctrl_q;
      OFF_COUNT:   rd_word = count_q;
      OFF_COMPARE: rd_word = compare_q;
      OFF_STATUS:  rd_word = {31'h0, match_q};
`ifdef MMIO_TIMER_PWM_EN
      OFF_DUTY:    rd_word = duty_q;
`endif
      default:     rd_word = '0;
    endcase
  end

  mmio_lane_align u_lane (
    .funct3      (funct3),
    .addr_lo     (dmem_address[1:0]),
    .store_data  (dmem_data_in),
    .old_word    (rd_word),
    .store_ok    (store_ok),
    .byte_en     (byte_en),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // Tick update first, then CPU stores override it; match set is applied
  // last so it wins over a same-cycle write-1-to-clear.
  always_comb begin : next_state
    pcnt_d    = (!ctrl_q.enable || tick) ? '0 : pcnt_q + PRESCALE_W'(1);
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;
`ifdef MMIO_TIMER_PWM_EN
    duty_d    = duty_q;
    pwm_d     = ctrl_q.enable && (count_q < duty_q);
`else
    pwm_d     = 1'b0;
`endif
    if (tick) begin
      if (match_hit) begin
        if (ctrl_q.auto_reload) count_d = '0;
        else                    ctrl_d.enable = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    if (wr) begin
      case ({idx, 2'b00})
        OFF_CTRL:    ctrl_d    = ctrl_t'(merged_word & ctrl_mask(PRESCALE_W));
        OFF_COUNT:   count_d   = merged_word;
        OFF_COMPARE: compare_d = merged_word;
        OFF_STATUS:  if (byte_en[0] && merged_word[0]) match_d = 1'b0;
`ifdef MMIO_TIMER_PWM_EN
        OFF_DUTY:    duty_d    = merged_word;
`endif
        default: ;
      endcase
    end
    if (match_hit) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      match_q       <= 1'b0;
      pcnt_q        <= '0;
      dmem_data_out <= '0;
      hit           <= 1'b0;
      irq           <= 1'b0;
      pwm_out       <= 1'b0;
`ifdef MMIO_TIMER_PWM_EN
      duty_q        <= '0;
`endif
    end else begin
      ctrl_q        <= ctrl_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      match_q       <= match_d;
      pcnt_q        <= pcnt_d;
      dmem_data_out <= sel ? load_data : '0;
      hit           <= sel;
      irq           <= match_q & ctrl_q.irq_en;
      pwm_out       <= pwm_d;
`ifdef MMIO_TIMER_PWM_EN
      duty_q        <= duty_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register access, auto-reload, W1C priority,
// one-shot prescaled counting, byte lanes, wrap, PWM and mid-count reset.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;
`ifdef MMIO_TIMER_PWM_EN
  localparam int          EXP_HIGHS = 6;
  localparam logic [31:0] EXP_DUTY  = 32'd3;
`else
  localparam int          EXP_HIGHS = 0;
  localparam logic [31:0] EXP_DUTY  = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = '0;
  logic [31:0] dmem_data_in = '0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] dmem_data_out;
  logic        hit, irq, pwm_out;
  int          errors = 0;
  int          checks = 0;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .dmem_wren(dmem_wren), .dmem_address(dmem_address),
    .dmem_data_in(dmem_data_in), .funct3(funct3), .dmem_data_out(dmem_data_out),
    .hit(hit), .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    dmem_wren = 1'b1; dmem_address = addr; dmem_data_in = data; funct3 = f3;
    step();
    dmem_wren = 1'b0; dmem_address = '0; dmem_data_in = '0; funct3 = F_W;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3);
    dmem_wren = 1'b0; dmem_address = addr; funct3 = f3;
    step();
  endtask

  task automatic idle();
    dmem_wren = 1'b0; dmem_address = '0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", dmem_data_out); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b want 0", hit); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load(BASE + 32'(4 * i), F_W);
      checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0", i, dmem_data_out); end
      checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_hit%0d: got %b want 1", i, hit); end
    end
    load(BASE + 32'h40, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL miss_data: got %h want 0", dmem_data_out); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", hit); end
  endtask

  task automatic test_autoreload();
    logic [31:0] exp_cnt [0:4];
    logic        exp_irq [0:4];
    exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    store(BASE + 32'h08, 32'd3, F_W);
    store(BASE + 32'h00, 32'h0000_0007, F_W);
    for (int i = 0; i < 5; i++) begin
      load(BASE + 32'h04, F_W);
      checks++; if (dmem_data_out !== exp_cnt[i]) begin errors++; $display("FAIL ar_count%0d: got %h want %h", i, dmem_data_out, exp_cnt[i]); end
      checks++; if (irq !== exp_irq[i]) begin errors++; $display("FAIL ar_irq%0d: got %b want %b", i, irq, exp_irq[i]); end
    end
    load(BASE + 32'h0C, F_W);
    checks++; if (dmem_data_out !== 32'h1) begin errors++; $display("FAIL ar_match: got %h want 1", dmem_data_out); end
  endtask

  task automatic test_w1c_priority();
    store(BASE + 32'h00, 32'h0, F_W);
    store(BASE + 32'h0C, 32'h1, F_W);
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h08, 32'd3, F_W);
    store(BASE + 32'h00, 32'h0000_0007, F_W);
    idle(); idle(); idle();
    store(BASE + 32'h0C, 32'h1, F_W);
    load(BASE + 32'h0C, F_W);
    checks++; if (dmem_data_out !== 32'h1) begin errors++; $display("FAIL w1c_vs_match: got %h want 1", dmem_data_out); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_set: got %b want 1", irq); end
    store(BASE + 32'h0C, 32'h1, F_W);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag: got %b want 1", irq); end
    store(BASE + 32'h00, 32'h0, F_W);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b want 0", irq); end
    load(BASE + 32'h0C, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL w1c_cleared: got %h want 0", dmem_data_out); end
  endtask

  task automatic test_oneshot();
    logic [31:0] exp_cnt [0:6];
    exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h08, 32'd1, F_W);
    store(BASE + 32'h00, 32'h0000_0201, F_W);
    for (int i = 0; i < 7; i++) begin
      load(BASE + 32'h04, F_W);
      checks++; if (dmem_data_out !== exp_cnt[i]) begin errors++; $display("FAIL os_count%0d: got %h want %h", i, dmem_data_out, exp_cnt[i]); end
    end
    load(BASE + 32'h00, F_W);
    checks++; if (dmem_data_out !== 32'h0000_0200) begin errors++; $display("FAIL os_ctrl: got %h want 00000200", dmem_data_out); end
    load(BASE + 32'h04, F_W);
    checks++; if (dmem_data_out !== 32'h1) begin errors++; $display("FAIL os_hold: got %h want 1", dmem_data_out); end
    load(BASE + 32'h0C, F_W);
    checks++; if (dmem_data_out !== 32'h1) begin errors++; $display("FAIL os_match: got %h want 1", dmem_data_out); end
    store(BASE + 32'h0C, 32'h1, F_W);
  endtask

  task automatic test_byte_lanes();
    store(BASE + 32'h08, 32'h0, F_W);
    store(BASE + 32'h09, 32'hABCD_EF80, F_B);
    load(BASE + 32'h08, F_W);
    checks++; if (dmem_data_out !== 32'h0000_8000) begin errors++; $display("FAIL sb_word: got %h want 00008000", dmem_data_out); end
    load(BASE + 32'h09, F_B);
    checks++; if (dmem_data_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: got %h want ffffff80", dmem_data_out); end
    load(BASE + 32'h09, F_BU);
    checks++; if (dmem_data_out !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", dmem_data_out); end
    load(BASE + 32'h0A, F_H);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL lh_hi: got %h want 0", dmem_data_out); end
    store(BASE + 32'h0B, 32'hFFFF_1234, F_H);
    load(BASE + 32'h08, F_W);
    checks++; if (dmem_data_out !== 32'h1234_8000) begin errors++; $display("FAIL sh_word: got %h want 12348000", dmem_data_out); end
    load(BASE + 32'h08, F_H);
    checks++; if (dmem_data_out !== 32'hFFFF_8000) begin errors++; $display("FAIL lh_lo: got %h want ffff8000", dmem_data_out); end
    load(BASE + 32'h0A, F_HU);
    checks++; if (dmem_data_out !== 32'h0000_1234) begin errors++; $display("FAIL lhu_hi: got %h want 00001234", dmem_data_out); end
    store(BASE + 32'h08, 32'hFFFF_FFFF, F_BAD);
    store(BASE + 32'h08, 32'h0000_0055, F_W);
    checks++; if (dmem_data_out !== 32'h1234_8000) begin errors++; $display("FAIL prewrite_read: got %h want 12348000", dmem_data_out); end
    load(BASE + 32'h08, F_W);
    checks++; if (dmem_data_out !== 32'h0000_0055) begin errors++; $display("FAIL sw_word: got %h want 00000055", dmem_data_out); end
    store(BASE + 32'h14, 32'hDEAD_BEEF, F_W);
    load(BASE + 32'h14, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want 0", dmem_data_out); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL unmapped_hit: got %b want 1", hit); end
  endtask

  task automatic test_wrap();
    store(BASE + 32'h08, 32'd5, F_W);
    store(BASE + 32'h04, 32'hFFFF_FFFF, F_W);
    store(BASE + 32'h00, 32'h0000_0001, F_W);
    load(BASE + 32'h04, F_W);
    checks++; if (dmem_data_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre: got %h want ffffffff", dmem_data_out); end
    load(BASE + 32'h04, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", dmem_data_out); end
    load(BASE + 32'h0C, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL wrap_nomatch: got %h want 0", dmem_data_out); end
    store(BASE + 32'h00, 32'h0, F_W);
  endtask

  task automatic test_pwm();
    int highs;
    highs = 0;
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h08, 32'd9, F_W);
    store(BASE + 32'h10, 32'd3, F_W);
    store(BASE + 32'h00, 32'h0000_0003, F_W);
    idle(); idle();
    for (int i = 0; i < 20; i++) begin
      idle();
      if (pwm_out === 1'b1) highs++;
    end
    checks++; if (highs !== EXP_HIGHS) begin errors++; $display("FAIL pwm_highs: got %0d want %0d", highs, EXP_HIGHS); end
    load(BASE + 32'h10, F_W);
    checks++; if (dmem_data_out !== EXP_DUTY) begin errors++; $display("FAIL duty_read: got %h want %h", dmem_data_out, EXP_DUTY); end
    store(BASE + 32'h00, 32'h0, F_W);
  endtask

  task automatic test_reset_midcount();
    store(BASE + 32'h04, 32'h0, F_W);
    store(BASE + 32'h08, 32'd2, F_W);
    store(BASE + 32'h00, 32'h0000_0007, F_W);
    idle(); idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b want 0", irq); end
    load(BASE + 32'h0C, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL mid_status: got %h want 0", dmem_data_out); end
    load(BASE + 32'h04, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL mid_count: got %h want 0", dmem_data_out); end
    load(BASE + 32'h00, F_W);
    checks++; if (dmem_data_out !== 32'h0) begin errors++; $display("FAIL mid_ctrl: got %h want 0", dmem_data_out); end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_w1c_priority();
    test_oneshot();
    test_byte_lanes();
    test_wrap();
    test_pwm();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
